// File: rtl/ft2232h_pkg.sv
// Shared constants and types for the FT2232H 245-mode receive controller.
package ft2232h_pkg;

    localparam logic [7:0] CMD_DIGIT_BASE = 8'h31;
    localparam logic [7:0] CMD_CLEAR      = 8'h43;
    localparam logic [7:0] CMD_FILL       = 8'h46;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        GAP
    } rx_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ft_rx_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
module ft_rx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             empty, full, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW + 1)'(DEPTH));
    assign do_pop  = pop_i && !empty;
    // A push into a full buffer is only taken when a pop frees the slot this cycle.
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = empty ? '0 : mem_q[rd_ptr_q];
    assign valid_o = !empty;
    assign count_o = count_q;

endmodule

// File: rtl/ft2232h_rx_multi_ctrl.sv
// FT2232H async-FIFO receive controller: RD# strobing with backpressure, ASCII
// channel-command decode and a FWFT stream buffer for downstream consumers.
module ft2232h_rx_multi_ctrl
    import ft2232h_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned RD_PULSE_CYC = 7,
    parameter int unsigned RD_GAP_CYC   = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [7:0]        usb_d_i,
    input  logic              usb_rxfn_i,
    output logic              usb_rdn_o,
    output logic [NUM_CH-1:0] ch_out_o,
    output logic [7:0]        rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              bad_cmd_o,
    output logic [CNT_W-1:0]  byte_count_o
);

    localparam int unsigned GAP_LEN = max_u(RD_GAP_CYC, SYNC_STAGES + 1);
    localparam int unsigned TMR_W   = $clog2(max_u(RD_PULSE_CYC, GAP_LEN));
    localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxf_s;
    rx_state_e              state_q, state_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic                   rdn_q, rdn_d;
    logic                   capture;
    logic [NUM_CH-1:0]      ch_q, ch_d;
    logic                   bad_q, bad_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   digit_hit;
    logic [FIFO_AW:0]       fifo_count;

    assign rxf_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], usb_rxfn_i};
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        rdn_d   = rdn_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Space is only checked here; pops during the strobe can only add room.
                if (!rxf_s && (fifo_count < (FIFO_AW + 1)'(FIFO_DEPTH))) begin
                    state_d = STROBE;
                    tmr_d   = '0;
                    rdn_d   = 1'b0;
                end
            end
            STROBE: begin
                if (tmr_q == TMR_W'(RD_PULSE_CYC - 1)) begin
                    capture = 1'b1;
                    state_d = GAP;
                    tmr_d   = '0;
                    rdn_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            GAP: begin
                // The IDLE decision cycle supplies the final high cycle of the gap.
                if (tmr_q == TMR_W'(GAP_LEN - 2)) begin
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                rdn_d   = 1'b1;
            end
        endcase
    end

    always_comb begin
        ch_d      = ch_q;
        bad_d     = 1'b0;
        cnt_d     = cnt_q;
        digit_hit = 1'b0;
        if (capture) begin
            cnt_d = cnt_q + 1'b1;
            for (int k = 0; k < NUM_CH; k++) begin
                if (usb_d_i == CMD_DIGIT_BASE + 8'(k)) begin
                    ch_d[k]   = ~ch_q[k];
                    digit_hit = 1'b1;
                end
            end
            if (!digit_hit) begin
                if (usb_d_i == CMD_CLEAR) begin
                    ch_d = '0;
                end else if (usb_d_i == CMD_FILL) begin
                    ch_d = '1;
                end else begin
                    bad_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            rdn_q   <= 1'b1;
            ch_q    <= '0;
            bad_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            rdn_q   <= rdn_d;
            ch_q    <= ch_d;
            bad_q   <= bad_d;
            cnt_q   <= cnt_d;
        end
    end

    ft_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (reset_i),
        .push_i  (capture),
        .wdata_i (usb_d_i),
        .pop_i   (rx_ready_i),
        .rdata_o (rx_data_o),
        .valid_o (rx_valid_o),
        .count_o (fifo_count)
    );

    assign usb_rdn_o    = rdn_q;
    assign ch_out_o     = ch_q;
    assign bad_cmd_o    = bad_q;
    assign byte_count_o = cnt_q;

endmodule

// File: tb/tb_ft2232h_rx_multi_ctrl.sv
// Self-checking bench: FT2232H device model, command/stream reference model,
// directed vector table and randomized traffic.
module tb_ft2232h_rx_multi_ctrl;

    localparam int NUM_CH  = 4;
    localparam int PULSE   = 7;
    localparam int GAPC    = 4;
    localparam int SYNC    = 2;
    localparam int DEPTH   = 8;
    localparam int GAP_LEN = (GAPC > SYNC + 1) ? GAPC : SYNC + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  usb_d;
    logic        usb_rxfn;
    logic        rx_ready;
    logic        usb_rdn, rx_valid, bad_cmd;
    logic [3:0]  ch_out;
    logic [7:0]  rx_data;
    logic [15:0] byte_count;
    logic        usb_rdn2, rx_valid2, bad_cmd2;
    logic [3:0]  ch_out2;
    logic [7:0]  rx_data2;
    logic [3:0]  byte_count2;

    always #4 clk = ~clk;

    ft2232h_rx_multi_ctrl #(
        .NUM_CH(NUM_CH), .RD_PULSE_CYC(PULSE), .RD_GAP_CYC(GAPC),
        .SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH), .CNT_W(16)
    ) dut (
        .clk_i(clk), .reset_i(reset), .usb_d_i(usb_d), .usb_rxfn_i(usb_rxfn),
        .usb_rdn_o(usb_rdn), .ch_out_o(ch_out), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
        .rx_ready_i(rx_ready), .bad_cmd_o(bad_cmd), .byte_count_o(byte_count)
    );

    // Narrow-counter instance sharing the same stimulus, for the wrap check.
    ft2232h_rx_multi_ctrl #(
        .NUM_CH(NUM_CH), .RD_PULSE_CYC(PULSE), .RD_GAP_CYC(GAPC),
        .SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH), .CNT_W(4)
    ) dut_w4 (
        .clk_i(clk), .reset_i(reset), .usb_d_i(usb_d), .usb_rxfn_i(usb_rxfn),
        .usb_rdn_o(usb_rdn2), .ch_out_o(ch_out2), .rx_data_o(rx_data2), .rx_valid_o(rx_valid2),
        .rx_ready_i(rx_ready), .bad_cmd_o(bad_cmd2), .byte_count_o(byte_count2)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Device and reference model state
    logic [7:0]  dev_q[$];
    logic [7:0]  exp_q[$];
    logic [3:0]  m_ch;
    int          m_cnt;
    logic        m_bad;
    int          low_cnt, high_cnt, strobes, captures;
    logic        prev_rdn, seen_strobe, cap_bad, cap;
    logic [7:0]  b;
    int          idx;
    int          rdy_mode;

    initial begin
        m_ch = '0; m_cnt = 0; low_cnt = 0; high_cnt = 0; strobes = 0; captures = 0;
        prev_rdn = 1'b1; seen_strobe = 1'b0; cap_bad = 1'b0; rdy_mode = 2;
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       rx_ready = 1'b0;
            1:       rx_ready = 1'($urandom_range(0, 1));
            default: rx_ready = 1'b1;
        endcase
    end

    // Monitor, model and device-side driver, all at the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            dev_q.delete();
            exp_q.delete();
            m_ch = '0; m_cnt = 0; low_cnt = 0; high_cnt = 0;
            prev_rdn = 1'b1; seen_strobe = 1'b0;
        end else begin
            cap   = 1'b0;
            m_bad = 1'b0;
            if (!usb_rdn) begin
                if (prev_rdn) begin
                    strobes++;
                    if (seen_strobe) chk("rd_gap_min", 32'(high_cnt >= GAP_LEN), 1);
                    seen_strobe = 1'b1;
                end
                low_cnt++;
            end else begin
                if (!prev_rdn) begin
                    cap = 1'b1;
                    chk("rd_low_cycles", low_cnt, PULSE);
                    low_cnt  = 0;
                    high_cnt = 0;
                    if (dev_q.size() == 0) begin
                        chk("read_without_data", 1, 0);
                    end else begin
                        b   = dev_q.pop_front();
                        idx = int'(b) - 'h31;
                        if (idx >= 0 && idx < NUM_CH) m_ch[idx] = ~m_ch[idx];
                        else if (b == 8'h43)          m_ch = '0;
                        else if (b == 8'h46)          m_ch = '1;
                        else                          m_bad = 1'b1;
                        m_cnt++;
                        exp_q.push_back(b);
                        chk("stream_no_overflow", 32'(exp_q.size() <= DEPTH), 1);
                        chk("ch_out", ch_out, m_ch);
                        chk("byte_count", byte_count, m_cnt % 65536);
                        chk("byte_count_w4", byte_count2, m_cnt % 16);
                    end
                    cap_bad = bad_cmd;
                    captures++;
                end
                high_cnt++;
            end
            chk("bad_cmd", bad_cmd, cap ? m_bad : 1'b0);
            chk("rx_valid", rx_valid, exp_q.size() != 0);
            if (rx_valid && rx_ready && exp_q.size() != 0) chk("rx_data", rx_data, exp_q.pop_front());
            prev_rdn = usb_rdn;
        end
        usb_rxfn = (dev_q.size() == 0);
        usb_d    = (dev_q.size() != 0) ? dev_q[0] : 8'($urandom);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_caps(input int target, input int limit);
        int t = 0;
        while (captures < target && t < limit) begin
            step();
            t++;
        end
        chk("wait_capture", captures, target);
    endtask

    task automatic wait_drain(input int limit);
        int t = 0;
        while ((dev_q.size() != 0 || exp_q.size() != 0) && t < limit) begin
            step();
            t++;
        end
        chk("drain", dev_q.size() + exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    typedef struct {
        logic [7:0] d;
        logic [3:0] ch;
        logic       bad;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #480000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, s0, t;
        tbl[0]  = '{8'h43, 4'b0000, 1'b0};
        tbl[1]  = '{8'h31, 4'b0001, 1'b0};
        tbl[2]  = '{8'h31, 4'b0000, 1'b0};
        tbl[3]  = '{8'h46, 4'b1111, 1'b0};
        tbl[4]  = '{8'h33, 4'b1011, 1'b0};
        tbl[5]  = '{8'h43, 4'b0000, 1'b0};
        tbl[6]  = '{8'h35, 4'b0000, 1'b1};
        tbl[7]  = '{8'h7A, 4'b0000, 1'b1};
        tbl[8]  = '{8'h34, 4'b1000, 1'b0};
        tbl[9]  = '{8'h32, 4'b1010, 1'b0};
        tbl[10] = '{8'h30, 4'b1010, 1'b1};
        tbl[11] = '{8'h46, 4'b1111, 1'b0};

        reset = 1'b1; usb_d = 8'h00; usb_rxfn = 1'b1; rx_ready = 1'b0;
        repeat (3) step();
        chk("rst_rdn", usb_rdn, 1'b1);
        chk("rst_ch", ch_out, 4'b0);
        chk("rst_valid", rx_valid, 1'b0);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_bad", bad_cmd, 1'b0);
        chk("rst_count", byte_count, 16'h0);
        reset = 1'b0;
        step();

        // Single read, held in the buffer
        rdy_mode = 0;
        c0 = captures;
        dev_q.push_back(8'h31);
        wait_caps(c0 + 1, 100);
        step();
        chk("single_ch", ch_out, 4'b0001);
        chk("single_count", byte_count, 16'd1);
        chk("single_data", rx_data, 8'h31);
        chk("single_valid", rx_valid, 1'b1);
        s0 = strobes;
        repeat (40) step();
        chk("no_second_strobe", strobes, s0);
        chk("rdn_idle_high", usb_rdn, 1'b1);
        rdy_mode = 2;
        wait_drain(100);

        // Command vector table
        for (int i = 0; i < 12; i++) begin
            c0 = captures;
            dev_q.push_back(tbl[i].d);
            wait_caps(c0 + 1, 100);
            step();
            chk("tbl_ch", ch_out, tbl[i].ch);
            chk("tbl_bad", cap_bad, tbl[i].bad);
        end
        wait_drain(100);

        // Reset on the third low cycle of RD#
        dev_q.push_back(8'h55);
        t = 0;
        while (!(usb_rdn == 1'b0 && low_cnt == 2) && t < 100) begin
            step();
            t++;
        end
        chk("reached_third_low", low_cnt, 2);
        reset = 1'b1;
        #1;
        chk("midrst_rdn", usb_rdn, 1'b1);
        chk("midrst_ch", ch_out, 4'b0);
        chk("midrst_valid", rx_valid, 1'b0);
        chk("midrst_count", byte_count, 16'h0);
        step();
        step();
        reset = 1'b0;
        step();

        // Counter wrap on the 4-bit instance
        c0 = captures;
        for (int i = 0; i < 17; i++) dev_q.push_back(8'($urandom));
        wait_caps(c0 + 17, 600);
        wait_drain(200);
        chk("wrap_count_w4", byte_count2, 4'd1);
        chk("wrap_count_w16", byte_count, 16'd17);

        // Backpressure: 20 bytes against a stalled consumer
        do_reset();
        rdy_mode = 0;
        c0 = captures;
        s0 = strobes;
        for (int i = 0; i < 20; i++) dev_q.push_back(8'h60 + 8'(i));
        repeat (300) step();
        chk("bp_strobes", strobes - s0, DEPTH);
        chk("bp_captures", captures - c0, DEPTH);
        chk("bp_rdn_high", usb_rdn, 1'b1);
        chk("bp_valid", rx_valid, 1'b1);
        rdy_mode = 2;
        wait_drain(600);
        chk("bp_total", byte_count, 16'd20);

        // Randomized traffic with a random consumer
        rdy_mode = 1;
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 3))
                0:       dev_q.push_back(8'h31 + 8'($urandom_range(0, 4)));
                1:       dev_q.push_back(8'h43);
                2:       dev_q.push_back(8'h46);
                default: dev_q.push_back(8'($urandom));
            endcase
            repeat ($urandom_range(0, 20)) step();
        end
        wait_drain(5000);
        chk("rand_count", byte_count, 16'(m_cnt));
        chk("rand_ch", ch_out, m_ch);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/ft2232h_rx_multi_ctrl.md
Name: ft2232h_rx_multi_ctrl

Overview:
- Generation-2 FT2232H async-FIFO (245-mode) receive controller.
- Drains bytes from the FT2232H read port with a programmable RD# strobe, and applies backpressure so no byte is read without buffer space.
- Decodes single-byte ASCII commands onto NUM_CH latched outputs (LEDs or enables).
- Forwards every received byte to a small stream buffer with valid/ready for downstream logic. Sits between the USB chip pins and the board control logic.

Parameters:
- NUM_CH, 4, number of latched output channels (1..9).
- RD_PULSE_CYC, 7, clk cycles RD# is held low (7 = 56 ns at 125 MHz); minimum 2.
- RD_GAP_CYC, 4, clk cycles RD# is held high after each read before the next may start; minimum 1.
- SYNC_STAGES, 2, flip-flop stages on usb_rxfn (>=2).
- FIFO_DEPTH, 8, stream buffer depth; power of 2, >=2.
- CNT_W, 16, width of the received-byte counter.

Ports:
- clk  in  1  system clock (125 MHz nominal).
- reset  in  1  asynchronous, active-high reset.
- usb_d  in  8  FT2232H data bus.
- usb_rxfn  in  1  FT2232H RXF#; low = data available. Asynchronous to clk.
- usb_rdn  out  1  FT2232H RD#, active low.
- ch_out  out  NUM_CH  latched channel outputs; bit k = channel k+1.
- rx_data  out  8  head byte of the stream buffer.
- rx_valid  out  1  stream buffer not empty.
- rx_ready  in  1  consumer accepts rx_data when rx_valid & rx_ready.
- bad_cmd  out  1  one-cycle pulse: received byte is not a valid command.
- byte_count  out  CNT_W  total bytes read; wraps modulo 2^CNT_W.

Behaviour:
- Reset values (asynchronous): usb_rdn=1, ch_out=0, rx_valid=0, rx_data=0, bad_cmd=0, byte_count=0. Stream buffer is empty, FSM is in IDLE, synchroniser flops are set to 1. Reset asserted mid-read releases RD# immediately; the partial byte is discarded.
- usb_rxfn passes through SYNC_STAGES flops; rxf_s is the synchronised value.
- FSM states and transitions:
  - IDLE -> STROBE when rxf_s==0 and buffer occupancy < FIFO_DEPTH. usb_rdn goes low on the registered transition edge.
  - STROBE: usb_rdn=0 for exactly RD_PULSE_CYC cycles. usb_d is captured on the clk edge that ends the last low cycle. On that edge, usb_rdn returns to 1 and the state goes to GAP.
  - GAP: usb_rdn=1 for max(RD_GAP_CYC, SYNC_STAGES+1) cycles, so a stale rxf_s cannot trigger a double read. Then -> IDLE.
- Capture edge actions, all in the same cycle:
  - The byte is pushed to the stream buffer.
  - byte_count increments.
  - The decoder acts on the byte; its effect on ch_out/bad_cmd is visible on the next cycle.
- Command decode (byte values):
  - 0x31..0x30+NUM_CH: toggle ch_out[byte-0x31].
  - 0x43 'C': ch_out = 0.
  - 0x46 'F': ch_out = all ones.
  - Any other value: ch_out unchanged; bad_cmd pulses 1 cycle.
  - Digits above NUM_CH count as bad commands.
- Backpressure: occupancy is checked only when leaving IDLE, which guarantees space at capture because pops during STROBE only free space. Buffer full with RXF# low leaves the FSM in IDLE with RD# high; no byte is lost.
- Stream buffer:
  - First-word-fall-through; rx_data is valid whenever rx_valid=1.
  - Push and pop in the same cycle keeps occupancy unchanged. This is legal when full only if the pop is also present.
  - Pointers wrap modulo FIFO_DEPTH.
  - Latency from capture edge to rx_valid=1 is 1 cycle when the buffer is empty.
- Sustained throughput: one byte per RD_PULSE_CYC + max(RD_GAP_CYC, SYNC_STAGES+1) cycles.
- usb_rxfn rising during STROBE does not abort the read; the strobe completes.

Decomposition:
- Package ft2232h_pkg: command byte constants (CMD_DIGIT_BASE=8'h31, CMD_CLEAR=8'h43, CMD_FILL=8'h46) and the FSM state enum (IDLE, STROBE, GAP).
- One sub-module, ft_rx_fifo: parametrised FWFT synchronous FIFO (DEPTH, WIDTH=8) with count output. The top level holds the synchroniser, FSM, decoder and counter.

Test Plan:
- Single read: after reset, drive usb_rxfn=0 and usb_d=8'h31. Required: usb_rdn low for exactly 7 cycles; ch_out=4'b0001; byte_count=1; rx_data=8'h31 with rx_valid=1. Then raise usb_rxfn; no second strobe occurs.
- Toggle and bulk: send 0x31, 0x31, 0x46, 0x33, 0x43. Required ch_out sequence: 0001, 0000, 1111, 1011, 0000; bad_cmd never asserted.
- Bad commands: send 0x35 (NUM_CH=4) and 0x7A. Required: one bad_cmd pulse per byte; ch_out unchanged; both bytes appear on the stream.
- Backpressure: hold rx_ready=0 and usb_rxfn=0 for 20 byte times. Required: exactly 8 strobes, then usb_rdn stays 1. Set rx_ready=1: bytes drain in order and strobes resume; byte_count ends at 20.
- Reset mid-strobe: assert reset on the 3rd low cycle of usb_rdn. Required: usb_rdn=1 in the same cycle (asynchronous); ch_out=0; rx_valid=0; byte_count=0.
- Counter wrap with CNT_W=4: 17 reads. Required: byte_count=1 afterwards.
